variable_latency_bank_adapter: RTL and testbench
================================================

VARIABLE_LATENCY_BANK_ADAPTER -- requirements
Module: variable_latency_bank_adapter

Interface
REQ-001 SHALL have parameter NumIn, default 32: number of network initiators; initiator-address width is IniAddWidth = $clog2(NumIn).
REQ-002 SHALL have parameter DataWidth, default 32: word width; byte-enable width is DataWidth/8.
REQ-003 SHALL have parameter AddrWidth, default 10: bank word-address width.
REQ-004 SHALL have parameter MemLatency, default 1: cycles from mem_req_o to valid mem_rdata_i; legal values are 1..4.
REQ-005 SHALL have parameter RespDepth, default 2: response FIFO entries; legal values are powers of 2 and at least 2.
REQ-006 SHALL have a single clock and a synchronous, active-high reset.
REQ-007 clk_i  in  1  clock; all state updates on the rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 req_valid_i  in  1  request valid from the butterfly target port.
REQ-010 req_ready_o  out  1  request ready.
REQ-011 req_ini_addr_i  in  IniAddWidth  requesting initiator.
REQ-012 req_wen_i / req_addr_i / req_be_i / req_wdata_i  in  1 / AddrWidth / DataWidth/8 / DataWidth  write-enable, word address, byte enables, write data.
REQ-013 mem_req_o / mem_we_o / mem_addr_o / mem_be_o / mem_wdata_o  out  1 / 1 / AddrWidth / DataWidth/8 / DataWidth  SRAM port.
REQ-014 mem_rdata_i  in  DataWidth  SRAM read data.
REQ-015 resp_valid_o  out  1  response valid toward the response network.
REQ-016 resp_ready_i  in  1  response ready.
REQ-017 resp_ini_addr_o / resp_rdata_o  out  IniAddWidth / DataWidth  response destination initiator and data.

Function
REQ-018 A request SHALL be accepted in a cycle only when req_valid_i and req_ready_o are both high.
REQ-019 mem_req_o SHALL be driven combinationally as req_valid_i && req_ready_o; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL pass through combinationally from the request inputs.
REQ-020 The block SHALL carry valid, ini_addr and wen for every accepted request through a MemLatency-stage shift pipeline.
REQ-021 When a pipeline entry reaches stage MemLatency and generates a response, the block SHALL push {ini_addr, data} into the response FIFO in that cycle; data is mem_rdata_i for a read and all zeros for a write.
REQ-022 The FIFO SHALL be registered with no fall-through: a read accepted in cycle T SHALL present resp_valid_o at the earliest in cycle T+MemLatency+1.
REQ-023 resp_valid_o SHALL equal FIFO not-empty, and resp_ini_addr_o and resp_rdata_o SHALL show the FIFO head entry.
REQ-024 A response SHALL be popped only when resp_valid_o and resp_ready_i are both high.
REQ-025 resp_ini_addr_o and resp_rdata_o SHALL be held stable while resp_valid_o is high and resp_ready_i is low.
REQ-026 A credit counter outstanding_q (width $clog2(RespDepth)+1) SHALL count responses that have been accepted but not yet popped.
REQ-027 outstanding_q SHALL increment when a response-generating request is accepted and SHALL decrement on a pop.
REQ-028 When an increment and a decrement occur in the same cycle, outstanding_q SHALL stay unchanged.
REQ-029 req_ready_o SHALL equal (outstanding_q < RespDepth) and SHALL depend on registered state only, with no combinational path from resp_ready_i.
REQ-030 Because of REQ-029, the FIFO SHALL never overflow; a push into a full FIFO SHALL be impossible by construction.
REQ-031 Requests SHALL return responses in acceptance order; one request SHALL be accepted per cycle back-to-back while credit is available.

Reset
REQ-032 While rst_i is high, the pipeline valids, FIFO pointers and outstanding_q SHALL be cleared at the clock edge.
REQ-033 After reset: req_ready_o = 1, resp_valid_o = 0, mem_req_o = 0 (in the absence of a request).
REQ-034 A reset asserted mid-operation SHALL discard all in-flight and buffered responses without emitting them.
REQ-035 FIFO data storage SHALL NOT require reset.

Configuration
REQ-036 With macro BANK_ADAPTER_WRITE_ACK_EN defined, writes SHALL generate a response (rdata all zeros), consume credit, and be returned in order with reads.
REQ-037 Without BANK_ADAPTER_WRITE_ACK_EN, writes SHALL generate no response and consume no credit, but SHALL still be accepted only while req_ready_o = 1.

Verification (NumIn=4, DataWidth=32, MemLatency=1, RespDepth=2)
REQ-038 Read test: reset, then a read with ini=2, addr=5 accepted in cycle 0 while the SRAM returns 0xDEADBEEF -> resp_valid_o=1 in cycle 2 with ini=2 and rdata=0xDEADBEEF; popped with resp_ready_i=1.
REQ-039 Credit-exhaustion test: resp_ready_i=0 and three back-to-back reads -> two accepted, req_ready_o=0 from cycle 2; raising resp_ready_i -> req_ready_o=1 one cycle after the first pop.
REQ-040 Simultaneous-event test: with outstanding_q=2 and a pop, the counter drops to 1; in the next cycle an accept together with a pop -> outstanding_q stays 1 and no request or response is lost.
REQ-041 Write test: a write with ini=3 -> with BANK_ADAPTER_WRITE_ACK_EN, one response with ini=3 and rdata=0; without the macro, no response and outstanding_q unchanged.
REQ-042 Reset-flush test: two responses buffered, assert rst_i for one cycle -> resp_valid_o=0 and req_ready_o=1 in the next cycle, and the discarded responses never appear.
REQ-043 Ordering test: 16 random-stall reads with random resp_ready_i -> responses match a scoreboard in order, and the FIFO never overflows.

Source files
------------

// File: rtl/variable_latency_bank_adapter.sv
// Adapts a fixed-latency SRAM bank to a valid/ready request/response network port.
// Optional macro BANK_ADAPTER_WRITE_ACK_EN makes writes return a zero-data response.
module variable_latency_bank_adapter #(
  parameter int unsigned NumIn       = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 10,
  parameter int unsigned MemLatency  = 1,
  parameter int unsigned RespDepth   = 2,
  localparam int unsigned IniAddWidth = $clog2(NumIn),
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IniAddWidth-1:0] req_ini_addr_i,
  input  logic                   req_wen_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [BeWidth-1:0]     req_be_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [BeWidth-1:0]     mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [IniAddWidth-1:0] resp_ini_addr_o,
  output logic [DataWidth-1:0]   resp_rdata_o
);

  localparam int unsigned PtrW = $clog2(RespDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(RespDepth);
  localparam logic [CntW-1:0] One      = CntW'(1);
`ifdef BANK_ADAPTER_WRITE_ACK_EN
  localparam bit WriteAck = 1'b1;
`else
  localparam bit WriteAck = 1'b0;
`endif

  logic accept, resp_gen, push, pop;

  logic [MemLatency-1:0]  vld_d, vld_q, wen_d, wen_q;
  logic [IniAddWidth-1:0] ini_d [MemLatency];
  logic [IniAddWidth-1:0] ini_q [MemLatency];

  logic [CntW-1:0] outstanding_d, outstanding_q;
  logic [CntW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;

  logic [IniAddWidth-1:0] fifo_ini_q  [RespDepth];
  logic [DataWidth-1:0]   fifo_data_q [RespDepth];

  // Ready comes from the credit counter only, so a full FIFO can never be pushed.
  assign req_ready_o = outstanding_q < DepthCnt;
  assign accept      = req_valid_i && req_ready_o;
  assign resp_gen    = accept && (WriteAck || !req_wen_i);

  assign mem_req_o   = accept;
  assign mem_we_o    = req_wen_i;
  assign mem_addr_o  = req_addr_i;
  assign mem_be_o    = req_be_i;
  assign mem_wdata_o = req_wdata_i;

  assign push         = vld_q[MemLatency-1] && (WriteAck || !wen_q[MemLatency-1]);
  assign resp_valid_o = wptr_q != rptr_q;
  assign pop          = resp_valid_o && resp_ready_i;

  assign resp_ini_addr_o = fifo_ini_q[rptr_q[PtrW-1:0]];
  assign resp_rdata_o    = fifo_data_q[rptr_q[PtrW-1:0]];

  always_comb begin
    vld_d    = '0;
    wen_d    = '0;
    ini_d    = ini_q;
    vld_d[0] = accept;
    wen_d[0] = req_wen_i;
    ini_d[0] = req_ini_addr_i;
    for (int unsigned i = 1; i < MemLatency; i++) begin
      vld_d[i] = vld_q[i-1];
      wen_d[i] = wen_q[i-1];
      ini_d[i] = ini_q[i-1];
    end

    outstanding_d = outstanding_q;
    if (resp_gen && !pop) begin
      outstanding_d = outstanding_q + One;
    end else if (!resp_gen && pop) begin
      outstanding_d = outstanding_q - One;
    end

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + One;
    if (pop)  rptr_d = rptr_q + One;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q         <= '0;
      outstanding_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      vld_q         <= vld_d;
      outstanding_q <= outstanding_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // Payload side of the pipeline is qualified by vld_q and needs no reset.
  always_ff @(posedge clk_i) begin
    wen_q <= wen_d;
    ini_q <= ini_d;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_ini_q[wptr_q[PtrW-1:0]]  <= ini_q[MemLatency-1];
      fifo_data_q[wptr_q[PtrW-1:0]] <= wen_q[MemLatency-1] ? '0 : mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_variable_latency_bank_adapter.sv
// Directed and table-driven bench for variable_latency_bank_adapter
// (NumIn=4, DataWidth=32, MemLatency=1, RespDepth=2).
module tb_variable_latency_bank_adapter;

`ifdef BANK_ADAPTER_WRITE_ACK_EN
  localparam logic AckEn = 1'b1;
`else
  localparam logic AckEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_ini = '0;
  logic        req_wen = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [3:0]  req_be = 4'hF;
  logic [31:0] req_wdata = '0;
  logic        mem_req_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid_o;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_ini_addr_o;
  logic [31:0] resp_rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  variable_latency_bank_adapter #(
    .NumIn(4), .DataWidth(32), .AddrWidth(10), .MemLatency(1), .RespDepth(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_ini_addr_i (req_ini),
    .req_wen_i      (req_wen),
    .req_addr_i     (req_addr),
    .req_be_i       (req_be),
    .req_wdata_i    (req_wdata),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready),
    .resp_ini_addr_o(resp_ini_addr_o),
    .resp_rdata_o   (resp_rdata_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [9:0] a);
    return (a == 10'd5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(a);
  endfunction

  // One-cycle-latency SRAM model.
  always @(posedge clk) begin
    if (mem_req_o && !mem_we_o) mem_rdata <= data_fn(mem_addr_o);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] ini,
                       input logic [9:0] a, input logic rr);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_wen    = w;
    req_ini    = ini;
    req_addr   = a;
    resp_ready = rr;
  endtask

  typedef struct {
    logic        valid;
    logic        wen;
    logic [1:0]  ini;
    logic [9:0]  addr;
    logic        rr;
    logic        e_ready;
    logic        e_mem_req;
    logic        e_rvalid;
    logic [1:0]  e_ini;
    logic [31:0] e_data;
    logic [1:0]  e_out;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] exp_q[$];
    int sent, got;

    // Read test, then credit exhaustion with a simultaneous accept+pop at row 9.
    vecs[0]  = '{1, 0, 2, 5, 1,  1, 1, 0, 0, 32'h0,         0};
    vecs[1]  = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0,         1};
    vecs[2]  = '{0, 0, 0, 0, 1,  1, 0, 1, 2, 32'hDEADBEEF,  1};
    vecs[3]  = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0,         0};
    vecs[4]  = '{1, 0, 1, 7, 0,  1, 1, 0, 0, 32'h0,         0};
    vecs[5]  = '{1, 0, 3, 8, 0,  1, 1, 0, 0, 32'h0,         1};
    vecs[6]  = '{1, 0, 0, 9, 0,  0, 0, 1, 1, 32'h1000_0007, 2};
    vecs[7]  = '{1, 0, 0, 9, 0,  0, 0, 1, 1, 32'h1000_0007, 2};
    vecs[8]  = '{1, 0, 0, 9, 1,  0, 0, 1, 1, 32'h1000_0007, 2};
    vecs[9]  = '{1, 0, 0, 9, 1,  1, 1, 1, 3, 32'h1000_0008, 1};
    vecs[10] = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0,         1};
    vecs[11] = '{0, 0, 0, 0, 1,  1, 0, 1, 0, 32'h1000_0009, 1};
    vecs[12] = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 32'h0,         0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready_o, 1);
    chk("reset_resp_valid", resp_valid_o, 0);
    chk("reset_mem_req", mem_req_o, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].wen, vecs[i].ini, vecs[i].addr, vecs[i].rr);
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), req_ready_o, vecs[i].e_ready);
      chk($sformatf("vec%0d_mem_req", i), mem_req_o, vecs[i].e_mem_req);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].addr);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid_o, vecs[i].e_rvalid);
      chk($sformatf("vec%0d_outstanding", i), dut.outstanding_q, vecs[i].e_out);
      if (vecs[i].e_rvalid) begin
        chk($sformatf("vec%0d_resp_ini", i), resp_ini_addr_o, vecs[i].e_ini);
        chk($sformatf("vec%0d_resp_rdata", i), resp_rdata_o, vecs[i].e_data);
      end
    end

    // Write: passthrough, then response only when write acks are enabled.
    drive(1, 1, 3, 2, 0);
    req_be    = 4'hA;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_mem_req", mem_req_o, 1);
    chk("wr_mem_we", mem_we_o, 1);
    chk("wr_mem_be", mem_be_o, 4'hA);
    chk("wr_mem_wdata", mem_wdata_o, 32'h1234_5678);
    drive(0, 0, 0, 0, 0);
    req_be = 4'hF;
    @(negedge clk);
    chk("wr_outstanding", dut.outstanding_q, {1'b0, AckEn});
    chk("wr_resp_valid_early", resp_valid_o, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_resp_valid", resp_valid_o, AckEn);
`ifdef BANK_ADAPTER_WRITE_ACK_EN
    chk("wr_resp_ini", resp_ini_addr_o, 3);
    chk("wr_resp_rdata", resp_rdata_o, 0);
`endif
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("wr_resp_valid_held", resp_valid_o, AckEn);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("wr_drained", resp_valid_o, 0);
    chk("wr_out_final", dut.outstanding_q, 0);

    // Reset flush with two buffered responses.
    drive(1, 0, 1, 30, 0);
    drive(1, 0, 2, 31, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_pre_valid", resp_valid_o, 1);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("flush_pre_out", dut.outstanding_q, 2);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("flush_resp_valid", resp_valid_o, 0);
    chk("flush_req_ready", req_ready_o, 1);
    chk("flush_out", dut.outstanding_q, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("flush_quiet%0d", i), resp_valid_o, 0);
    end

    // Ordering under random request stalls and random response backpressure.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      drive((sent < 16) && ($urandom_range(0, 3) != 0), 0, 2'(sent % 4), 10'(20 + sent),
            1'($urandom_range(0, 1)));
      @(negedge clk);
      if (req_valid && req_ready_o) begin
        exp_q.push_back({req_ini, data_fn(req_addr)});
        sent++;
      end
      chk("ord_credit_bound", dut.outstanding_q <= 2'd2, 1);
      if (resp_valid_o && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ord_unexpected: got response ini %0h data %0h, expected none",
                   resp_ini_addr_o, resp_rdata_o);
        end else begin
          chk("ord_resp", {resp_ini_addr_o, resp_rdata_o}, exp_q.pop_front());
        end
        got++;
      end
    end
    chk("ord_count", got, 16);

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("end_idle_valid", resp_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
